div_job_scheduler: RTL and testbench

- Initiator side of the divider en/Select/Busy/Ready handshake.
- Arbitrates between two independent requester channels (A, B), latches their operands and drives the shared divider with one job at a time.
- Waits for completion, captures the quotient and returns it to the requesting channel as a one-cycle result strobe.
- Sits between the measurement/display logic and the 16-bit restoring divider.

---
 rtl/div_job_scheduler_pkg.sv | 18 +
 rtl/div_job_scheduler_rr_arbiter.sv | 37 +++
 rtl/div_job_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_div_job_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_job_scheduler_pkg.sv
// Shared definitions for the divider job scheduler.
// State codes, channel IDs (matching div_select polarity) and default width.
package div_job_scheduler_pkg;

    localparam int DEF_WIDTH = 16;

    localparam logic CH_A = 1'b1;
    localparam logic CH_B = 1'b0;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ISSUE = 3'd1;
    localparam state_t ST_RUN   = 3'd2;
    localparam state_t ST_DONE  = 3'd3;
    localparam state_t ST_GAP   = 3'd4;

endpackage

// File: rtl/div_job_scheduler_rr_arbiter.sv
// div_rr_arbiter: two-requester round-robin arbiter.
// Grant is combinational while enabled; the pointer moves on i_toggle.
module div_rr_arbiter
    import div_job_scheduler_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_toggle,
    output logic o_grant,
    output logic o_grant_ch
);

    logic r_ptr;
    logic r_last;
    logic w_both;

    assign w_both     = i_req_a & i_req_b;
    assign o_grant    = i_en & (i_req_a | i_req_b);
    assign o_grant_ch = w_both ? r_ptr : (i_req_a ? CH_A : CH_B);

    // Pointer favours whichever channel was not served by the finished job.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr  <= CH_A;
            r_last <= CH_B;
        end else begin
            if (o_grant)
                r_last <= o_grant_ch;
            if (i_toggle)
                r_ptr <= ~r_last;
        end
    end

endmodule

// File: rtl/div_job_scheduler.sv
// div_job_scheduler: serves channels A/B one job at a time on a shared divider.
// Define DIV_TIMEOUT_EN to add a per-job watchdog that reports err.
module div_job_scheduler
    import div_job_scheduler_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_req,
    input  logic [WIDTH-1:0] a_dividend,
    input  logic [WIDTH-1:0] a_divisor,
    output logic             a_ack,
    output logic             a_res_valid,
    output logic [WIDTH-1:0] a_res,
    input  logic             b_req,
    input  logic [WIDTH-1:0] b_dividend,
    input  logic [WIDTH-1:0] b_divisor,
    output logic             b_ack,
    output logic             b_res_valid,
    output logic [WIDTH-1:0] b_res,
    output logic             err,
    output logic             div_en,
    output logic             div_select,
    output logic [WIDTH-1:0] div_dividend1,
    output logic [WIDTH-1:0] div_divisor1,
    output logic [WIDTH-1:0] div_dividend2,
    output logic [WIDTH-1:0] div_divisor2,
    input  logic [WIDTH-1:0] div_res,
    input  logic             div_busy,
    input  logic             div_ready
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t           r_state;
    logic             r_owner;
    logic [GW-1:0]    r_gap;
    logic             r_a_ack;
    logic             r_b_ack;
    logic             r_sel;
    logic [WIDTH-1:0] r_a_res;
    logic [WIDTH-1:0] r_b_res;
    logic [WIDTH-1:0] r_dd1;
    logic [WIDTH-1:0] r_dv1;
    logic [WIDTH-1:0] r_dd2;
    logic [WIDTH-1:0] r_dv2;

    logic             w_idle;
    logic             w_active;
    logic             w_done;
    logic             w_div_ok;
    logic             w_timeout;
    logic             w_finish;
    logic             w_grant;
    logic             w_grant_ch;
    logic [WIDTH-1:0] w_result;

    assign w_idle   = r_state == ST_IDLE;
    assign w_active = (r_state == ST_ISSUE) | (r_state == ST_RUN);
    assign w_done   = r_state == ST_DONE;
    // Ready is only trusted in RUN; in ISSUE it may be left over from the last job.
    assign w_div_ok = (r_state == ST_RUN) & div_ready;

`ifdef DIV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_tmo;
    logic          r_err;

    assign w_timeout = w_active & (r_tmo == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || !w_active)
            r_tmo <= '0;
        else
            r_tmo <= r_tmo + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_err <= 1'b0;
        else if (w_active && w_finish)
            r_err <= ~w_div_ok;
    end

    assign err = w_done & r_err;
`else
    logic w_unused_tmo;

    assign w_timeout    = 1'b0;
    assign w_unused_tmo = TIMEOUT_CYCLES == 0;
    assign err          = 1'b0;
`endif

    assign w_finish = w_div_ok | w_timeout;
    assign w_result = w_div_ok ? div_res : '1;

    div_rr_arbiter u_arb (
        .clk        (clk),
        .reset      (reset),
        .i_en       (w_idle),
        .i_req_a    (a_req),
        .i_req_b    (b_req),
        .i_toggle   (w_done),
        .o_grant    (w_grant),
        .o_grant_ch (w_grant_ch)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_gap   <= '0;
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            r_sel   <= 1'b0;
            r_a_res <= '0;
            r_b_res <= '0;
            r_dd1   <= '0;
            r_dv1   <= '0;
            r_dd2   <= '0;
            r_dv2   <= '0;
        end else begin
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_owner <= w_grant_ch;
                        r_sel   <= w_grant_ch;
                        r_state <= ST_ISSUE;
                        if (w_grant_ch == CH_A) begin
                            r_a_ack <= 1'b1;
                            r_dd1   <= a_dividend;
                            r_dv1   <= a_divisor;
                        end else begin
                            r_b_ack <= 1'b1;
                            r_dd2   <= b_dividend;
                            r_dv2   <= b_divisor;
                        end
                    end
                end
                ST_ISSUE, ST_RUN: begin
                    if (w_finish) begin
                        r_state <= ST_DONE;
                        if (r_owner == CH_A)
                            r_a_res <= w_result;
                        else
                            r_b_res <= w_result;
                    end else if (r_state == ST_ISSUE && div_busy) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    r_gap   <= '0;
                    r_state <= ST_GAP;
                end
                ST_GAP: begin
                    if (r_gap == GW'(GAP_CYCLES - 1))
                        r_state <= ST_IDLE;
                    else
                        r_gap <= r_gap + 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign a_ack         = r_a_ack;
    assign b_ack         = r_b_ack;
    assign a_res_valid   = w_done & (r_owner == CH_A);
    assign b_res_valid   = w_done & (r_owner == CH_B);
    assign a_res         = r_a_res;
    assign b_res         = r_b_res;
    assign div_en        = w_active;
    assign div_select    = r_sel;
    assign div_dividend1 = r_dd1;
    assign div_divisor1  = r_dv1;
    assign div_dividend2 = r_dd2;
    assign div_divisor2  = r_dv2;

endmodule

// File: tb/tb_div_job_scheduler.sv
// Randomised scoreboard bench for div_job_scheduler with a behavioural divider.
// Define DIV_TIMEOUT_EN to also exercise the watchdog against a hung divider.
`timescale 1ns/1ps
module tb_div_job_scheduler;

    localparam int W   = 16;
    localparam int GAP = 2;
`ifdef DIV_TIMEOUT_EN
    localparam int TMO = 50;
`else
    localparam int TMO = 255;
`endif

    typedef struct packed {
        logic [W-1:0] dd;
        logic [W-1:0] dv;
        logic         tmo;
    } job_t;

    typedef struct packed {
        logic [W-1:0] q;
        logic         err;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         a_req, b_req;
    logic [W-1:0] a_dividend, a_divisor, b_dividend, b_divisor;
    logic         a_ack, b_ack, a_res_valid, b_res_valid, err;
    logic [W-1:0] a_res, b_res;
    logic         div_en, div_select;
    logic [W-1:0] div_dividend1, div_divisor1, div_dividend2, div_divisor2;
    logic [W-1:0] div_res;
    logic         div_busy, div_ready;
    logic         hang;

    job_t a_jobs[$], b_jobs[$];
    exp_t a_exp[$], b_exp[$];

    int n_tests = 0;
    int n_fail  = 0;

    div_job_scheduler #(
        .WIDTH(W), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_dividend(a_dividend), .a_divisor(a_divisor),
        .a_ack(a_ack), .a_res_valid(a_res_valid), .a_res(a_res),
        .b_req(b_req), .b_dividend(b_dividend), .b_divisor(b_divisor),
        .b_ack(b_ack), .b_res_valid(b_res_valid), .b_res(b_res),
        .err(err), .div_en(div_en), .div_select(div_select),
        .div_dividend1(div_dividend1), .div_divisor1(div_divisor1),
        .div_dividend2(div_dividend2), .div_divisor2(div_divisor2),
        .div_res(div_res), .div_busy(div_busy), .div_ready(div_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [79:0] got,
                         input logic [79:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic job_t mk(input int dd, input int dv, input bit tmo);
        job_t j;
        j.dd  = W'(dd);
        j.dv  = W'(dv);
        j.tmo = tmo;
        return j;
    endfunction

    function automatic exp_t ref_result(input job_t j);
        exp_t e;
        e.err = j.tmo;
        if (j.tmo)
            e.q = '1;
        else if (j.dv == 0)
            e.q = '0;
        else
            e.q = j.dd / j.dv;
        return e;
    endfunction

    // Behavioural divider: busy for a random latency, then ready held until next start.
    logic         m_run, m_wait;
    int           m_cnt;
    logic [W-1:0] m_q;
    always @(posedge clk) begin
        if (reset) begin
            div_busy <= 1'b0; div_ready <= 1'b0; div_res <= '0;
            m_run <= 1'b0; m_wait <= 1'b0; m_cnt <= 0; m_q <= '0;
        end else if (m_run) begin
            if (!hang) begin
                if (m_cnt <= 1) begin
                    div_busy <= 1'b0; div_ready <= 1'b1; div_res <= m_q;
                    m_run <= 1'b0; m_wait <= 1'b1;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end else if (m_wait) begin
            if (!div_en) m_wait <= 1'b0;
        end else if (div_en) begin
            logic [W-1:0] dd, dv;
            dd = div_select ? div_dividend1 : div_dividend2;
            dv = div_select ? div_divisor1 : div_divisor2;
            m_run <= 1'b1; div_busy <= 1'b1; div_ready <= 1'b0;
            m_q   <= (dv == 0) ? '0 : dd / dv;
            m_cnt <= (dv == 0) ? 2 : 60 + int'($urandom_range(0, 8));
        end
    end

    // Values the DUT saw at each active edge.
    logic         rst_p, pa, pb;
    logic [W-1:0] pdd_a, pdv_a, pdd_b, pdv_b;
    always @(posedge clk) begin
        rst_p <= reset; pa <= a_req; pb <= b_req;
        pdd_a <= a_dividend; pdv_a <= a_divisor;
        pdd_b <= b_dividend; pdv_b <= b_divisor;
    end

    initial begin : drv_a
        job_t j;
        bit   got;
        a_req = 1'b0; a_dividend = '0; a_divisor = '0;
        forever begin
            @(negedge clk);
            if (a_jobs.size() != 0) begin
                j = a_jobs.pop_front();
                a_dividend = j.dd; a_divisor = j.dv; a_req = 1'b1;
                got = 1'b0;
                for (int k = 0; k < 4000 && !got; k++) begin
                    @(negedge clk);
                    got = a_ack;
                end
                if (got) a_exp.push_back(ref_result(j));
                else check("a_ack_wait", 0, 1);
                a_req = 1'b0;
            end
        end
    end

    initial begin : drv_b
        job_t j;
        bit   got;
        b_req = 1'b0; b_dividend = '0; b_divisor = '0;
        forever begin
            @(negedge clk);
            if (b_jobs.size() != 0) begin
                j = b_jobs.pop_front();
                b_dividend = j.dd; b_divisor = j.dv; b_req = 1'b1;
                got = 1'b0;
                for (int k = 0; k < 4000 && !got; k++) begin
                    @(negedge clk);
                    got = b_ack;
                end
                if (got) b_exp.push_back(ref_result(j));
                else check("b_ack_wait", 0, 1);
                b_req = 1'b0;
            end
        end
    end

    // Monitor: arbitration model, operand-latch model, gap and result scoreboard.
    initial begin : monitor
        logic         last, sel_m, exp_ch;
        logic [W-1:0] p1d, p1v, p2d, p2v;
        int           low;
        bit           seen, en_d;
        exp_t         e;
        forever begin
            @(negedge clk);
            if (rst_p !== 1'b0) begin
                last = 1'b0; sel_m = 1'b0;
                p1d = '0; p1v = '0; p2d = '0; p2v = '0;
                low = 0; seen = 0; en_d = 0;
                continue;
            end
            if (a_ack || b_ack) begin
                check("single_ack", a_ack & b_ack, 0);
                exp_ch = (pa && pb) ? ~last : pa;
                check("grant_ch", a_ack, exp_ch);
                check("req_at_grant", a_ack ? pa : pb, 1);
                check("en_after_ack", div_en, 1);
                last  = a_ack;
                sel_m = a_ack;
                if (a_ack) begin p1d = pdd_a; p1v = pdv_a; end
                else       begin p2d = pdd_b; p2v = pdv_b; end
            end
            check("latches", {div_select, div_dividend1, div_divisor1,
                              div_dividend2, div_divisor2},
                  {sel_m, p1d, p1v, p2d, p2v});
            if (div_en && !en_d && seen) check("gap_low", low >= GAP, 1);
            if (div_en) low = 0;
            else low++;
            if (!div_en && en_d) seen = 1;
            en_d = div_en;
            if (a_res_valid && b_res_valid) check("both_valid", 1, 0);
            if (a_res_valid) begin
                if (a_exp.size() == 0) check("a_unexpected", 1, 0);
                else begin
                    e = a_exp.pop_front();
                    check("a_res", a_res, e.q);
                    check("a_err", err, e.err);
                end
            end
            if (b_res_valid) begin
                if (b_exp.size() == 0) check("b_unexpected", 1, 0);
                else begin
                    e = b_exp.pop_front();
                    check("b_res", b_res, e.q);
                    check("b_err", err, e.err);
                end
            end
            if (err && !a_res_valid && !b_res_valid) check("err_stray", 1, 0);
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_ack"}, {a_ack, b_ack}, 0);
        check({tag, "_valid"}, {a_res_valid, b_res_valid}, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_en"}, div_en, 0);
        check({tag, "_sel"}, div_select, 0);
        check({tag, "_res"}, {a_res, b_res}, 0);
        check({tag, "_pair1"}, {div_dividend1, div_divisor1}, 0);
        check({tag, "_pair2"}, {div_dividend2, div_divisor2}, 0);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((a_jobs.size() != 0 || b_jobs.size() != 0 || a_exp.size() != 0 ||
                b_exp.size() != 0 || a_req || b_req) && k < 6000) begin
            @(negedge clk);
            k++;
        end
        check(name, k < 6000, 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        a_exp.delete(); b_exp.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
    endtask

    initial begin : main
        int k;
        reset = 1'b1;
        hang  = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("rst");
        reset = 1'b0;

        @(posedge clk);
        a_jobs.push_back(mk(100, 7, 0));
        wait_idle("a_only_done");

        do_reset();
        a_jobs.push_back(mk(1000, 10, 0));
        b_jobs.push_back(mk(65535, 255, 0));
        wait_idle("same_cycle_done");

        @(posedge clk);
        b_jobs.push_back(mk(5, 0, 0));
        wait_idle("div0_done");

        do_reset();
        for (int i = 0; i < 3; i++) begin
            a_jobs.push_back(mk(1000 + i, 3 + i, 0));
            b_jobs.push_back(mk(2000 + i, 7 + i, 0));
        end
        wait_idle("alternate_done");

        for (int i = 0; i < 24; i++) begin
            job_t j;
            int   r;
            repeat ($urandom_range(0, 90)) @(posedge clk);
            r = int'($urandom_range(0, 7));
            j.dd  = W'($urandom());
            j.dv  = (r == 0) ? '0 : (r < 3) ? W'($urandom_range(1, 15)) : W'($urandom());
            j.tmo = 1'b0;
            if ($urandom_range(0, 1) == 1) a_jobs.push_back(j);
            else b_jobs.push_back(j);
        end
        wait_idle("random_done");

        @(posedge clk);
        a_jobs.push_back(mk(4321, 3, 0));
        k = 0;
        while (!div_en && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("midjob_started", div_en, 1);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        a_exp.delete(); b_exp.delete();
        @(negedge clk);
        check_zero("midrst");
        reset = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        a_jobs.push_back(mk(50000, 123, 0));
        wait_idle("after_reset_done");

`ifdef DIV_TIMEOUT_EN
        hang = 1'b1;
        @(posedge clk);
        a_jobs.push_back(mk(77, 7, 1));
        wait_idle("timeout_done");
        check("timeout_idle", div_en, 0);
        hang = 1'b0;
        do_reset();
        b_jobs.push_back(mk(900, 30, 0));
        wait_idle("post_timeout_done");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
